// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-iteration multi-cycle multiply/divide unit with architectural HI/LO registers.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        is_div, neg_q, neg_r;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc;
  logic        sgn, ge;
  logic [31:0] abs_a, abs_b, diff, quot, rem;
  logic [32:0] add;
  logic [63:0] prod;
  assign sgn   = ~op[0];
  assign abs_a = (sgn && a[31]) ? -a : a;
  assign abs_b = (sgn && b[31]) ? -b : b;
  // multiply: add multiplicand into the high half when the low bit is set, then shift right with carry
  assign add   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
  // divide: the 33-bit partial remainder is acc[63:31]; a successful subtract always fits in 32 bits
  assign ge    = acc[63:31] >= {1'b0, mag_b};
  assign diff  = acc[62:31] - mag_b;
  assign prod  = neg_q ? -acc : acc;
  assign quot  = neg_q ? -acc[31:0] : acc[31:0];
  assign rem   = neg_r ? -acc[63:32] : acc[63:32];
  assign busy  = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !cancel) begin
          if (!op[2]) begin
            is_div <= op[1];
            // a zero divisor must yield an all-ones quotient regardless of signs
            neg_q  <= sgn & (a[31] ^ b[31]) & ~(op[1] & (b == 32'd0));
            neg_r  <= op[1] & sgn & a[31];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            acc    <= {32'd0, op[1] ? abs_a : abs_b};
            cnt    <= '0;
            state  <= CALC;
          end else if (!op[1]) begin
            if (op[0]) lo <= a;
            else hi <= a;
          end
        end
        CALC: if (cancel) state <= IDLE;
        else begin
          acc <= is_div ? (ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0}) : {add, acc[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            hi   <= is_div ? rem : prod[63:32];
            lo   <= is_div ? quot : prod[31:0];
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          total = 0, passed = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic [31:0] corners [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
  mul_div_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
    total++;
    if (got !== expv) $display("FAIL %s: got %h expected %h", tag, got, expv);
    else passed++;
  endtask
  function automatic logic [63:0] ref_model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    logic [63:0] ux = {32'd0, x};
    logic [63:0] uy = {32'd0, y};
    longint q, r;
    if (o == 3'd0) return sx * sy;
    if (o == 3'd1) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd3) return {x % y, x / y};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic run_op(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    int n = 0;
    logic [63:0] r;
    logic dropped = 1'b0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("done_single", 32'(done), 32'd0);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) dropped = 1'b1;
    end
    r = ref_model(o, x, y);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk("latency", n, 33);
    chk("busy_held", 32'(dropped), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
  endtask
  function automatic logic [31:0] pick();
    return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd100, 32'd0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("done_drop", 32'(done), 32'd0);
    for (int i = 0; i < 40; i++) run_op(3'($urandom_range(0, 3)), pick(), pick());
    // no-op codes leave HI/LO alone
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_hi", hi, exp_hi);
    chk("nop_lo", lo, exp_lo);
    // back-to-back MTHI then MTLO
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_done", 32'(done), 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    op = 3'd5; a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_done", 32'(done), 32'd0);
    chk("mtlo_hi", hi, exp_hi);
    chk("mtlo_lo", lo, exp_lo);
    // cancel in IDLE blocks acceptance
    start = 1'b1; op = 3'd5; a = 32'h5555_AAAA; cancel = 1'b1;
    @(posedge clk); #1;
    op = 3'd0;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cidle_busy", 32'(busy), 32'd0);
    chk("cidle_lo", lo, exp_lo);
    // DIVU cancelled during CALC, with MTHI attempts while busy
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    op = 3'd4; a = 32'hCAFE_F00D;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b1;
    chk("ccalc_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("ccalc_busy", 32'(busy), 32'd0);
    chk("ccalc_hi", hi, exp_hi);
    chk("ccalc_lo", lo, exp_lo);
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) chk("ccalc_quiet", {30'd0, busy, done}, 32'd0);
    end
    chk("ccalc_hi_late", hi, exp_hi);
    // cancel during FIX wins over the result write
    start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("cfix_busy_pre", 32'(busy), 32'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cfix_busy", 32'(busy), 32'd0);
    chk("cfix_done", 32'(done), 32'd0);
    chk("cfix_lo", lo, exp_lo);
    chk("cfix_hi", hi, exp_hi);
    // reset in the middle of a MULT
    start = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'hFFFF_0003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1; cancel = 1'b1; op = 3'd4;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; cancel = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    run_op(3'd0, 32'd6, 32'd7);
    chk("after_rst_lo", lo, 32'd42);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 SHALL have port a  input  32  forwarded rs operand (multiplicand/dividend/MT source).
REQ-007 SHALL have port b  input  32  forwarded rt operand (multiplier/divisor).
REQ-008 SHALL have port cancel  input  1  pipeline flush; aborts an in-flight operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; the hazard unit stalls MFHI/MFLO/MULT/DIV on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse when new HI/LO results from MULT/MULTU/DIV/DIVU first become visible.
REQ-011 SHALL have port hi  output  32  architectural HI register, read directly by MFHI.
REQ-012 SHALL have port lo  output  32  architectural LO register, read directly by MFLO.

Function
REQ-013 SHALL implement a state machine with states IDLE, CALC and FIX; busy = (state != IDLE).
REQ-014 In IDLE with start=1 and op in {000..011}, SHALL latch the magnitudes of a and b (two's-complement absolute value for signed ops, raw values for unsigned ops), latch the result signs, clear the iteration counter and enter CALC.
REQ-015 In IDLE with start=1 and op=100/101, SHALL write a into hi/lo at that edge, SHALL NOT assert busy, and SHALL NOT pulse done.
REQ-016 In IDLE with start=1 and op=110/111, or with start=0, SHALL change no state.
REQ-017 While busy=1, SHALL ignore start and op, including MTHI and MTLO.
REQ-018 CALC SHALL perform exactly 32 iterations, one per cycle: radix-2 shift-add for multiply and restoring shift-subtract for divide, using 64-bit internal accumulators.
REQ-019 After the 32nd iteration, SHALL enter FIX.
REQ-020 In FIX, SHALL apply sign correction and write hi/lo at the end of that cycle, then return to IDLE.
REQ-021 Sign correction for MULT SHALL negate the 64-bit product when the operand signs differ.
REQ-022 Sign correction for DIV SHALL negate the quotient when the operand signs differ and SHALL give the remainder the sign of the dividend.
REQ-023 Latency: for start accepted at edge E0, busy SHALL be high for exactly 33 cycles, hi/lo SHALL update at edge E33, and done SHALL be high for exactly the one cycle following E33.
REQ-024 Multiply results: hi = product[63:32], lo = product[31:0].
REQ-025 Divide results: lo = quotient, hi = remainder.
REQ-026 Divide by zero SHALL NOT raise a fault, SHALL keep normal latency, and SHALL give lo = 32'hFFFF_FFFF and hi = a, for both DIV and DIVU.
REQ-027 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000 and hi = 0.
REQ-028 cancel=1 while in CALC or FIX SHALL force IDLE at the next edge, with hi/lo unchanged and no done pulse.
REQ-029 cancel SHALL take priority over the FIX write.
REQ-030 cancel=1 in IDLE SHALL block acceptance of start in that cycle.
REQ-031 Operand inputs a and b SHALL be sampled only at acceptance; changes on them during CALC SHALL NOT affect the result.
REQ-032 A new start SHALL be accepted in the same cycle that done is high, since the unit is IDLE.

Reset
REQ-033 reset=1 at a rising edge SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear all internal registers.
REQ-034 reset SHALL take priority over cancel and start.
REQ-035 reset asserted mid-operation SHALL discard the operation without a done pulse.

Verification
REQ-036 MULTU a=32'hFFFF_FFFF, b=32'h0000_0002 -> busy high 33 cycles; hi=32'h0000_0001, lo=32'hFFFF_FFFE; single done pulse.
REQ-037 MULT a=-3 (32'hFFFF_FFFD), b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-038 DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU a=100, b=0 -> lo=32'hFFFF_FFFF, hi=100.
REQ-039 MTHI a=32'h1234_5678, then MTLO a=32'h9ABC_DEF0 on consecutive cycles -> both written, busy never high, done never high.
REQ-040 DIVU a=1000, b=3 started, cancel at cycle 10 -> IDLE next cycle, hi/lo keep prior values, no done; a later start with MTHI while busy is ignored.
REQ-041 Reset asserted at cycle 20 of a MULT -> all outputs 0 at the next edge; a subsequent MULT a=6, b=7 -> lo=42, hi=0.
